// File: rtl/traffic_display.sv
// traffic_display: converts the controller countdown to two BCD digits,
// multiplexes them onto a shared seven-segment bus and drives the lamps,
// blinking GREEN while the displayed countdown is 3 or less.
module traffic_display #(
    parameter int unsigned REFRESH_DIV = 16,
    parameter int unsigned BLINK_DIV   = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] n,
    input  logic [2:0] light,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic [2:0] lamp,
    output logic       busy
);

    localparam int unsigned N_W    = 5;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned REF_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                capture;
    logic                last_iter;

    logic [N_W-1:0]      n_q;
    logic [N_W-1:0]      bin_sh;
    logic [N_W-1:0]      bin_nx;
    logic [BCD_W-1:0]    bcd_sh;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_nx;
    logic [ITER_W-1:0]   iter_q;
    logic                pending_q;
    logic [3:0]          tens_q;
    logic [3:0]          ones_q;

    logic [REF_W-1:0]    refresh_cnt;
    logic                digit_sel_q;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_on_q;
    logic                low_value;

    // Seven-segment pattern for one BCD digit; anything out of range shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Conversion FSM next state: capture when idle and the value is stale.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q || (n != n_q)) begin
                    capture = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (iter_q == ITER_W'(N_W - 1)) begin
                    last_iter = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One shift-add-3 step: adjust nibbles >= 5, then shift the whole register left.
    always_comb begin
        bcd_adj[3:0] = (bcd_sh[3:0] >= 4'd5) ? bcd_sh[3:0] + 4'd3 : bcd_sh[3:0];
        bcd_adj[7:4] = (bcd_sh[7:4] >= 4'd5) ? bcd_sh[7:4] + 4'd3 : bcd_sh[7:4];
        {bcd_nx, bin_nx} = {bcd_adj, bin_sh} << 1;
    end

    // Conversion datapath; displayed digits only change on the final step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n_q       <= '0;
            bin_sh    <= '0;
            bcd_sh    <= '0;
            iter_q    <= '0;
            pending_q <= 1'b1;
            tens_q    <= '0;
            ones_q    <= '0;
        end else if (capture) begin
            n_q       <= n;
            bin_sh    <= n;
            bcd_sh    <= '0;
            iter_q    <= '0;
            pending_q <= 1'b0;
        end else if (state_q == S_CONV) begin
            bin_sh <= bin_nx;
            bcd_sh <= bcd_nx;
            iter_q <= iter_q + ITER_W'(1);
            if (last_iter) begin
                tens_q <= bcd_nx[7:4];
                ones_q <= bcd_nx[3:0];
            end
        end
    end

    // Digit refresh timer: toggle the active digit every REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_sel_q <= 1'b0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_sel_q <= ~digit_sel_q;
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Free-running blink timer: toggle blink phase every BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt  <= '0;
            blink_on_q <= 1'b1;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt  <= '0;
            blink_on_q <= ~blink_on_q;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    // Digit mux with leading-zero blanking of the tens digit.
    always_comb begin
        seg      = 7'h00;
        digit_en = 2'b00;
        if (!digit_sel_q) begin
            digit_en = 2'b01;
            seg      = seg_decode(ones_q);
        end else if (tens_q != 4'd0) begin
            digit_en = 2'b10;
            seg      = seg_decode(tens_q);
        end
    end

    // Lamp drive: fail-safe RED on illegal codes, blink GREEN at low countdown.
    always_comb begin
        low_value = (tens_q == 4'd0) && (ones_q <= 4'd3);
        case (light)
            3'b001:  lamp = 3'b001;
            3'b010:  lamp = 3'b010;
            3'b100:  lamp = (low_value && !blink_on_q) ? 3'b000 : 3'b100;
            default: lamp = 3'b001;
        endcase
    end

    assign busy = (state_q == S_CONV);

endmodule

// File: tb/tb_traffic_display.sv
// tb_traffic_display: directed vector table plus hand-written sequences for
// reset, back-to-back updates, blinking and reset during conversion.
module tb_traffic_display;

    localparam int unsigned REF = 4;
    localparam int unsigned BLK = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] n;
    logic [2:0] light;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic [2:0] lamp;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    traffic_display #(.REFRESH_DIV(REF), .BLINK_DIV(BLK)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .n        (n),
        .light    (light),
        .seg      (seg),
        .digit_en (digit_en),
        .lamp     (lamp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] n;
        logic [2:0] light;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [1:0] tens_en;
        logic [2:0] lamp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // advance one clock and land on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watch a full refresh period and record what each digit slot shows.
    task automatic observe(output logic [6:0] ones_seg, output logic [6:0] tens_seg,
                           output logic [1:0] tens_en);
        ones_seg = 'x;
        tens_seg = 'x;
        tens_en  = 'x;
        for (int i = 0; i < int'(2 * REF); i++) begin
            if (digit_en == 2'b01) ones_seg = seg;
            else begin
                tens_seg = seg;
                tens_en  = digit_en;
            end
            tick();
        end
    endtask

    // Check the digit currently on the bus against an expected pair.
    task automatic check_shown(input string name, input logic [6:0] ones_exp,
                               input logic [6:0] tens_exp, input logic [1:0] en_exp);
        if (digit_en == 2'b01) check(name, 16'({digit_en, seg}), 16'({2'b01, ones_exp}));
        else                   check(name, 16'({digit_en, seg}), 16'({en_exp, tens_exp}));
    endtask

    // Full display + lamp check after the value has settled.
    task automatic check_display(input string name, input logic [6:0] ones_exp,
                                 input logic [6:0] tens_exp, input logic [1:0] en_exp,
                                 input logic [2:0] lamp_exp);
        logic [6:0] o, t;
        logic [1:0] e;
        check({name, "_lamp"}, 16'(lamp), 16'(lamp_exp));
        observe(o, t, e);
        check({name, "_ones"}, 16'(o), 16'(ones_exp));
        check({name, "_tens"}, 16'({e, t}), 16'({en_exp, tens_exp}));
    endtask

    // Count cycles over a window where the lamp deviates from a steady value.
    task automatic check_lamp_steady(input string name, input logic [2:0] exp, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (lamp !== exp) bad++;
            tick();
        end
        check(name, 16'(bad), 16'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] hist[24];
        int         last_t, n_trans, bad_runs, bad_vals;

        vecs[0]  = '{5'd27, 3'b001, 7'h07, 7'h5B, 2'b10, 3'b001};
        vecs[1]  = '{5'd14, 3'b010, 7'h66, 7'h06, 2'b10, 3'b010};
        vecs[2]  = '{5'd9,  3'b100, 7'h6F, 7'h00, 2'b00, 3'b100};
        vecs[3]  = '{5'd31, 3'b100, 7'h06, 7'h4F, 2'b10, 3'b100};
        vecs[4]  = '{5'd20, 3'b011, 7'h3F, 7'h5B, 2'b10, 3'b001};
        vecs[5]  = '{5'd5,  3'b000, 7'h6D, 7'h00, 2'b00, 3'b001};
        vecs[6]  = '{5'd18, 3'b110, 7'h7F, 7'h06, 2'b10, 3'b001};
        vecs[7]  = '{5'd0,  3'b010, 7'h3F, 7'h00, 2'b00, 3'b010};
        vecs[8]  = '{5'd13, 3'b100, 7'h4F, 7'h06, 2'b10, 3'b100};
        vecs[9]  = '{5'd16, 3'b001, 7'h7D, 7'h06, 2'b10, 3'b001};
        vecs[10] = '{5'd2,  3'b011, 7'h5B, 7'h00, 2'b00, 3'b001};
        vecs[11] = '{5'd1,  3'b000, 7'h06, 7'h00, 2'b00, 3'b001};

        // reset hold
        reset_n = 1'b0;
        n       = 5'd9;
        light   = 3'b001;
        @(negedge clk);
        repeat (3) tick();
        check("rst_busy", 16'(busy), 16'(1'b0));
        check("rst_en", 16'(digit_en), 16'(2'b01));
        check("rst_seg", 16'(seg), 16'(7'h3F));
        check("rst_lamp", 16'(lamp), 16'(3'b001));

        // release: forced conversion of 9
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rel_busy_hi", 16'(busy), 16'(1'b1));
        end
        tick();
        check("rel_busy_lo", 16'(busy), 16'(1'b0));
        check_display("rel", 7'h6F, 7'h00, 2'b00, 3'b001);

        // vector table
        foreach (vecs[i]) begin
            n     = vecs[i].n;
            light = vecs[i].light;
            repeat (8) tick();
            check($sformatf("vec%0d_busy", i), 16'(busy), 16'(1'b0));
            check_display($sformatf("vec%0d", i), vecs[i].ones, vecs[i].tens,
                          vecs[i].tens_en, vecs[i].lamp);
        end

        // back-to-back: 1 -> 27 then 14 right after capture
        n     = 5'd27;
        light = 3'b001;
        tick();
        check("b2b_cap_busy", 16'(busy), 16'(1'b1));
        n = 5'd14;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b2b_c1_busy", 16'(busy), 16'(1'b1));
            check_shown("b2b_c1_old", 7'h06, 7'h00, 2'b00);
        end
        tick();
        check("b2b_idle", 16'(busy), 16'(1'b0));
        check_shown("b2b_27a", 7'h07, 7'h5B, 2'b10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b2b_c2_busy", 16'(busy), 16'(1'b1));
            check_shown("b2b_27b", 7'h07, 7'h5B, 2'b10);
        end
        tick();
        check("b2b_done", 16'(busy), 16'(1'b0));
        check_display("b2b_14", 7'h66, 7'h06, 2'b10, 3'b001);

        // blink: green at 5, 4 steady; at 3 blinks
        light = 3'b100;
        n     = 5'd5;
        repeat (8) tick();
        check_lamp_steady("blink_5", 3'b100, 8);
        n = 5'd4;
        repeat (8) tick();
        check_lamp_steady("blink_4", 3'b100, 8);
        n = 5'd3;
        check_lamp_steady("blink_conv", 3'b100, 5);
        tick();
        check("blink_busy", 16'(busy), 16'(1'b0));
        for (int i = 0; i < 24; i++) begin
            hist[i] = lamp;
            tick();
        end
        last_t   = -1;
        n_trans  = 0;
        bad_runs = 0;
        bad_vals = 0;
        for (int i = 0; i < 24; i++) begin
            if (hist[i] !== 3'b100 && hist[i] !== 3'b000) bad_vals++;
            if (i > 0 && hist[i] !== hist[i-1]) begin
                if (last_t >= 0 && (i - last_t) != int'(BLK)) bad_runs++;
                last_t = i;
                n_trans++;
            end
        end
        check("blink_vals", 16'(bad_vals), 16'(0));
        check("blink_period", 16'(bad_runs), 16'(0));
        check("blink_toggles", 16'(n_trans >= 4), 16'(1'b1));
        light = 3'b010;
        n     = 5'd2;
        repeat (8) tick();
        check_lamp_steady("yellow_2", 3'b010, 8);

        // reset pulse mid-conversion of 31
        n     = 5'd31;
        light = 3'b001;
        tick();
        tick();
        check("mid_busy", 16'(busy), 16'(1'b1));
        reset_n = 1'b0;
        tick();
        check("mid_rst_busy", 16'(busy), 16'(1'b0));
        check("mid_rst_en", 16'(digit_en), 16'(2'b01));
        check("mid_rst_seg", 16'(seg), 16'(7'h3F));
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_rel_busy", 16'(busy), 16'(1'b1));
        end
        tick();
        check("mid_rel_done", 16'(busy), 16'(1'b0));
        check_display("mid_31", 7'h06, 7'h4F, 2'b10, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
